pc_seq_ctrl: RTL
================

// Module: pc_seq_ctrl
// PURPOSE
//  Multi-cycle control sequencer for the stack processor. Drives the PC subsystem controls
//  (PCWrite, BEQCond, BNECond, PCSource) plus IR load and memory strobes. It steps each
//  instruction through fetch/decode/execute/memory/writeback on one clock.
//  Sits between instruction memory / IR and the PC subsystem; decodes opcode IR[15:12].
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles waiting for mem_ready in FETCH/MEM before FAULT (1..255)
//  CNT_W         16  width of instr_count (used only with RETIRE_CNT_EN)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   leave IDLE/HALT/FAULT and begin fetching
//  opcode       in   4   IR[15:12] of the instruction in the IR
//  mem_ready    in   1   memory handshake: access complete this cycle
//  zero         in   1   ALU zero flag, valid in BRANCH state
//  PCWrite      out  1   unconditional PC load
//  BEQCond      out  1   PC load if zero
//  BNECond      out  1   PC load if ~zero
//  PCSource     out  2   0=PC+1, 1={PC[15:12],IR[11:0]}, 2=aWire (stack top)
//  IRWrite      out  1   load IR from memory data
//  mem_rd       out  1   memory read strobe
//  mem_wr       out  1   memory write strobe
//  reg_write    out  1   stack/register writeback
//  halted       out  1   high in HALT
//  fault        out  1   high in FAULT (memory timeout or illegal opcode)
//  instr_count  out  CNT_W  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: one clock domain (clk); reset is asynchronous and active-high; state=IDLE,
//    wait counter=0, instr_count=0. All outputs are 0 in IDLE.
//  - Outputs are Moore: decoded combinationally from the state register only; the branch
//    qualification with zero happens in the PC subsystem, not here.
//  - States/outputs/transitions:
//    IDLE    : none. start -> FETCH.
//    FETCH   : mem_rd=1. On mem_ready: also IRWrite=1, PCWrite=1, PCSource=0 -> DECODE.
//              IRWrite/PCWrite are gated by mem_ready, the only non-Moore term.
//    DECODE  : none. Opcode 0 ALU -> EXEC; 1 LOAD and 2 STORE -> MEM; 3 J, 4 JR, 5 BEQ, 6 BNE
//              -> BRANCH; F HALT -> HALT; 7..E -> FAULT.
//    EXEC    : ALU cycle, no strobes -> WB.
//    MEM     : mem_rd=1 for LOAD, mem_wr=1 for STORE (opcode latched at DECODE). On mem_ready:
//              LOAD -> WB, STORE -> FETCH.
//    WB      : reg_write=1 -> FETCH.
//    BRANCH  : J: PCWrite=1, PCSource=1. JR: PCWrite=1, PCSource=2.
//              BEQ: BEQCond=1, PCSource=1. BNE: BNECond=1, PCSource=1. -> FETCH.
//    HALT    : halted=1. start -> FETCH. PC is not modified.
//    FAULT   : fault=1. start -> FETCH. Only reset or start leaves FAULT.
//  - Latched opcode: captured on DECODE entry; later opcode input changes are ignored.
//  - Wait counter: counts cycles in FETCH/MEM with mem_ready=0 and clears on state change.
//    When it reaches MEM_WAIT_MAX with mem_ready still 0 -> FAULT.
//    mem_ready in that same cycle wins (normal transition).
//  - Latency, no waits: ALU 4 cycles, LOAD 4, STORE 3, branch/jump 3, HALT 2 to halted.
//  - At most one of PCWrite/BEQCond/BNECond is high in any cycle.
//    mem_rd and mem_wr are never high together.
//  - start is ignored outside IDLE/HALT/FAULT.
//  - Reset mid-instruction: immediate return to IDLE, no strobe outputs in the reset cycle.
// CONFIGURATION
//  RETIRE_CNT_EN defined:
//    - instr_count increments by 1 on each transition into FETCH from WB, MEM (STORE)
//      or BRANCH; it does not count HALT or FAULT.
//    - Wraps at 2^CNT_W-1 -> 0 and is cleared by reset only.
//  RETIRE_CNT_EN undefined: instr_count tied to 0; no counter flops.
// TESTING
//  1 reset=1 mid-FETCH, release, start=1, opcode=0, mem_ready=1 every cycle
//    -> states FETCH,DECODE,EXEC,WB,FETCH; PCWrite=1 only in FETCH with PCSource=0.
//  2 opcode=5 (BEQ), zero=1 in BRANCH -> BEQCond=1, PCSource=1 for exactly 1 cycle.
//    opcode=6 -> BNECond=1; both BEQCond and BNECond are never high together.
//  3 opcode=4 (JR) -> BRANCH has PCWrite=1, PCSource=2. opcode=3 -> PCSource=1.
//  4 mem_ready held 0 in FETCH, MEM_WAIT_MAX=15 -> fault=1 after 15 wait cycles.
//    Repeat with mem_ready=1 on cycle 15 -> DECODE, no fault.
//  5 opcode=F -> halted=1, outputs static for 20 cycles; start=1 -> FETCH.
//    opcode=9 -> fault=1.
//  6 RETIRE_CNT_EN, CNT_W=4: retire 17 ALU instructions -> instr_count=1 (wrapped).
//    Undefined -> instr_count=0 throughout.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer for the stack CPU.
// Optional retired-instruction counter is built only when RETIRE_CNT_EN is defined.
module pc_seq_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             PCWrite,
  output logic             BEQCond,
  output logic             BNECond,
  output logic [1:0]       PCSource,
  output logic             IRWrite,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_write,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_BRANCH = 4'd6,
    ST_HALT   = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_J     = 4'h3;
  localparam logic [3:0] OP_JR    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_BNE   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [7:0] WAIT_MAX_C = 8'(MEM_WAIT_MAX);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] op_r;
  logic [7:0] wait_cnt_r;
  logic       waiting_s;
  logic       wait_hit_s;
  logic       zero_unused_s;

  // Branch qualification with zero is done in the PC subsystem.
  assign zero_unused_s = zero;

  assign waiting_s  = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
  assign wait_hit_s = (wait_cnt_r == (WAIT_MAX_C - 8'd1));

  // State register, opcode latch and memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      op_r       <= 4'h0;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        op_r <= opcode;
      end
      if (state_nxt_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if (waiting_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
    end
  end

  // Next-state decode and Moore outputs (FETCH load strobes gated by mem_ready).
  always_comb begin
    state_nxt_s = state_r;
    PCWrite     = 1'b0;
    BEQCond     = 1'b0;
    BNECond     = 1'b0;
    PCSource    = 2'd0;
    IRWrite     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_write   = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          IRWrite     = 1'b1;
          PCWrite     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (wait_hit_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_ALU:                        state_nxt_s = ST_EXEC;
          OP_LOAD, OP_STORE:             state_nxt_s = ST_MEM;
          OP_J, OP_JR, OP_BEQ, OP_BNE:   state_nxt_s = ST_BRANCH;
          OP_HALT:                       state_nxt_s = ST_HALT;
          default:                       state_nxt_s = ST_FAULT;
        endcase
      end
      ST_EXEC: state_nxt_s = ST_WB;
      ST_MEM: begin
        mem_rd = (op_r == OP_LOAD);
        mem_wr = (op_r == OP_STORE);
        if (mem_ready) begin
          if (op_r == OP_LOAD) state_nxt_s = ST_WB;
          else                 state_nxt_s = ST_FETCH;
        end else if (wait_hit_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write   = 1'b1;
        state_nxt_s = ST_FETCH;
      end
      ST_BRANCH: begin
        case (op_r)
          OP_J:    begin PCWrite = 1'b1; PCSource = 2'd1; end
          OP_JR:   begin PCWrite = 1'b1; PCSource = 2'd2; end
          OP_BEQ:  begin BEQCond = 1'b1; PCSource = 2'd1; end
          OP_BNE:  begin BNECond = 1'b1; PCSource = 2'd1; end
          default: begin PCSource = 2'd0; end
        endcase
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_HALT;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_FAULT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] instr_count_r;
  logic             retire_s;

  assign retire_s = (state_nxt_s == ST_FETCH) &&
                    ((state_r == ST_WB) || (state_r == ST_MEM) || (state_r == ST_BRANCH));

  // Retired-instruction counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instr_count = instr_count_r;
`else
  assign instr_count = {CNT_W{1'b0}};
`endif

endmodule
